// File: rtl/ysyx_22050078_lsu_pkg.sv
// Shared definitions for the LS-stage memory controller.
//  - funct3 load/store codes
//  - controller state encoding
//  - byte-enable masks and alignment helper, both indexed by access size (funct3[1:0])
package ysyx_22050078_lsu_pkg;

  localparam int LSU_DW = 64;
  localparam int LSU_AW = 64;

  localparam logic [2:0] FUNC_B  = 3'd0;
  localparam logic [2:0] FUNC_H  = 3'd1;
  localparam logic [2:0] FUNC_W  = 3'd2;
  localparam logic [2:0] FUNC_D  = 3'd3;
  localparam logic [2:0] FUNC_BU = 3'd4;
  localparam logic [2:0] FUNC_HU = 3'd5;
  localparam logic [2:0] FUNC_WU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Byte-enable pattern for an access of 1/2/4/8 bytes starting at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Natural alignment: the low log2(bytes) address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (off[0] == 1'b0);
      2'd2:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_22050078_lsu_load_align.sv
// Load data alignment: selects the addressed bytes out of the aligned
// doubleword and sign- or zero-extends them according to funct3.
// Ports:
//  i_rdata  aligned doubleword returned by memory
//  i_off    byte offset of the access inside the doubleword
//  i_func   RV funct3 of the load
//  o_data   extended load result
module ysyx_22050078_lsu_load_align
  import ysyx_22050078_lsu_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [DW-1:0] i_rdata,
  input  logic [2:0]    i_off,
  input  logic [2:0]    i_func,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] shifted;

  assign shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = shifted;
    case (i_func)
      FUNC_B:  o_data = {{(DW-8){shifted[7]}},   shifted[7:0]};
      FUNC_H:  o_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
      FUNC_W:  o_data = {{(DW-32){shifted[31]}}, shifted[31:0]};
      FUNC_BU: o_data = {{(DW-8){1'b0}},         shifted[7:0]};
      FUNC_HU: o_data = {{(DW-16){1'b0}},        shifted[15:0]};
      FUNC_WU: o_data = {{(DW-32){1'b0}},        shifted[31:0]};
      default: o_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22050078_lsu_mem_ctrl.sv
// LS-stage data-memory initiator. Takes one load/store from EX/LS, issues it
// on a valid/ready request channel, waits for the response, and produces the
// extended load result for the LS/WB register. Upstream is stalled until the
// access completes.
// Ports:
//  i_clk, i_rst                 clock, async active-high reset
//  i_lsu_*                      instruction from EX/LS (valid, load/store, funct3, addr, wdata)
//  o_lsu_stall/done/misalign    pipeline control and status pulses
//  o_lsu_lsres                  load result, held until the next load completes
//  o_mem_req_*                  request channel (aligned addr, lane-shifted data, byte mask)
//  i_mem_resp_*, o_mem_resp_ready  response channel
//
// state | meaning
// IDLE  | waiting for a memory instruction; accept or flag misalignment
// REQ   | request valid held until memory takes it
// WAIT  | request taken, waiting for read data / write ack
// DONE  | one-cycle completion pulse, pipeline released
module ysyx_22050078_lsu_mem_ctrl
  import ysyx_22050078_lsu_pkg::*;
#(
  parameter int DW = LSU_DW,
  parameter int AW = LSU_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_lsu_req_valid,
  input  logic          i_lsu_lden,
  input  logic          i_lsu_sten,
  input  logic [2:0]    i_lsu_func,
  input  logic [AW-1:0] i_lsu_addr,
  input  logic [DW-1:0] i_lsu_wdata,
  output logic          o_lsu_stall,
  output logic          o_lsu_done,
  output logic          o_lsu_misalign,
  output logic [DW-1:0] o_lsu_lsres,
  output logic          o_mem_req_valid,
  input  logic          i_mem_req_ready,
  output logic          o_mem_req_wen,
  output logic [AW-1:0] o_mem_req_addr,
  output logic [DW-1:0] o_mem_req_wdata,
  output logic [7:0]    o_mem_req_wmask,
  input  logic          i_mem_resp_valid,
  input  logic [DW-1:0] i_mem_resp_rdata,
  output logic          o_mem_resp_ready
);

  lsu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    func_q, func_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] lsres_q, lsres_d;

  logic          mem_op;
  logic          req_aligned;
  logic          accept;
  logic          misalign;
  logic [2:0]    off_q;
  logic [DW-1:0] load_data;

  assign mem_op      = i_lsu_lden | i_lsu_sten;
  assign req_aligned = is_aligned(i_lsu_func[1:0], i_lsu_addr[2:0]);
  assign accept      = (state_q == ST_IDLE) & i_lsu_req_valid & mem_op & req_aligned;
  assign misalign    = (state_q == ST_IDLE) & i_lsu_req_valid & mem_op & ~req_aligned;
  assign off_q       = addr_q[2:0];

  ysyx_22050078_lsu_load_align #(
    .DW(DW)
  ) u_load_align (
    .i_rdata(i_mem_resp_rdata),
    .i_off  (off_q),
    .i_func (func_q),
    .o_data (load_data)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)           state_d = ST_REQ;
      ST_REQ:  if (i_mem_req_ready)  state_d = ST_WAIT;
      ST_WAIT: if (i_mem_resp_valid) state_d = ST_DONE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Outputs; payload is forced to zero outside REQ so the bus is quiet when idle.
  always_comb begin
    o_lsu_stall      = 1'b0;
    o_lsu_done       = 1'b0;
    o_lsu_misalign   = 1'b0;
    o_mem_req_valid  = 1'b0;
    o_mem_req_wen    = 1'b0;
    o_mem_req_addr   = '0;
    o_mem_req_wdata  = '0;
    o_mem_req_wmask  = '0;
    o_mem_resp_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_lsu_stall    = accept;
        o_lsu_misalign = misalign;
      end
      ST_REQ: begin
        o_lsu_stall     = 1'b1;
        o_mem_req_valid = 1'b1;
        o_mem_req_wen   = wen_q;
        o_mem_req_addr  = {addr_q[AW-1:3], 3'b000};
        o_mem_req_wdata = wdata_q << {off_q, 3'b000};
        o_mem_req_wmask = size_mask(func_q[1:0]) << off_q;
      end
      ST_WAIT: begin
        o_lsu_stall      = 1'b1;
        o_mem_resp_ready = 1'b1;
      end
      default: begin
        o_lsu_done = 1'b1;
      end
    endcase
  end

  assign o_lsu_lsres = lsres_q;

  // Transaction latches and load result
  always_comb begin
    addr_d  = addr_q;
    func_d  = func_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    lsres_d = lsres_q;
    if (accept) begin
      addr_d  = i_lsu_addr;
      func_d  = i_lsu_func;
      wdata_d = i_lsu_wdata;
      wen_d   = i_lsu_sten;
    end
    if ((state_q == ST_WAIT) && i_mem_resp_valid && !wen_q) begin
      lsres_d = load_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      func_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      lsres_q <= '0;
    end else begin
      addr_q  <= addr_d;
      func_q  <= func_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      lsres_q <= lsres_d;
    end
  end

endmodule
